demux_1t4r: RTL and testbench

- Registered 1-to-4 demultiplexer. It is the distribution counterpart of the 4:1 selectors in the SD library.
- Routes one input word to one of four held output lanes. The lane is chosen either by an explicit select (direct mode) or by an internal rotating pointer (round-robin mode).
- Tracks lane validity, pulses a frame-complete strobe once all four lanes are written, and flags overwrites.
- Sits downstream of a serial/shared bus and feeds four parallel consumers.

---
 rtl/demux_1t4r_pkg.sv | 43 ++++
 rtl/demux_1t4r_lane.sv | 26 ++
 rtl/demux_1t4r.sv | 115 +++++++++++
 tb/tb_demux_1t4r.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux_1t4r_pkg.sv
// Shared definitions for the 1-to-4 registered demultiplexer:
// lane indices, mode encoding and the lane one-hot helper.
package demux_1t4r_pkg;

   // Lane indexing
   localparam int LANE_W    = 2;
   localparam int NUM_LANES = 4;

   typedef logic [LANE_W-1:0]    lane_t;
   typedef logic [NUM_LANES-1:0] lane_mask_t;

   localparam lane_t LANE_A = 2'd0;
   localparam lane_t LANE_B = 2'd1;
   localparam lane_t LANE_C = 2'd2;
   localparam lane_t LANE_D = 2'd3;

   // Routing mode: explicit select or rotating pointer
   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   // Frame mask with every lane written
   localparam lane_mask_t FRAME_FULL = '1;

   // Decoded view of the current write request
   typedef struct packed {
      logic       wr;    // accepted write this edge (En and not Clr)
      lane_t      lane;  // target lane
      lane_mask_t oh;    // one-hot of target lane
      logic       hit;   // target lane already valid in this frame
      logic       full;  // this write completes the frame
   } wr_ctl_t;

   // One-hot mask for a lane index
   function automatic lane_mask_t lane_onehot(input lane_t l);
      lane_mask_t m;
      m    = '0;
      m[l] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/demux_1t4r_lane.sv
// One held output lane: a WIDTH-bit register that loads when its lane is
// the target of an accepted write, and otherwise keeps its value.
module demux_lane
   import demux_1t4r_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Hold register with synchronous clear and load enable
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/demux_1t4r.sv
// Registered 1-to-4 demultiplexer. One input word is routed to one of four
// held lanes, chosen by Sel (direct mode) or by a rotating pointer
// (round-robin mode). Per-lane valid bits track the current frame; Done
// pulses when the frame fills and Ovr pulses when a valid lane is rewritten.
// All outputs come straight from flops.
module demux_1t4r
   import demux_1t4r_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] Din,
   input  logic             En,
   input  logic             Mode,
   input  logic [1:0]       Sel,
   input  logic             Clr,
   output logic [WIDTH-1:0] QA,
   output logic [WIDTH-1:0] QB,
   output logic [WIDTH-1:0] QC,
   output logic [WIDTH-1:0] QD,
   output logic [3:0]       Vld,
   output logic [1:0]       Ptr,
   output logic             Done,
   output logic             Ovr
);

   wr_ctl_t    ctl;
   lane_mask_t lane_load;

   // Decode the target lane and classify the write against the frame state
   always_comb begin
      // NOTE: every field gets a default first so no path leaves a latch.
      ctl      = '0;
      ctl.wr   = En & ~Clr;
      ctl.lane = (mode_e'(Mode) == MODE_RR) ? lane_t'(Ptr) : lane_t'(Sel);
      ctl.oh   = lane_onehot(ctl.lane);
      ctl.hit  = |(Vld & ctl.oh);
      ctl.full = ((Vld | ctl.oh) == FRAME_FULL);
   end

   // Only the target lane loads; a cleared cycle drops the write entirely
   assign lane_load = ctl.wr ? ctl.oh : '0;

   demux_lane #(.WIDTH(WIDTH)) u_lane_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load[LANE_A]),
      .d     (Din),
      .q     (QA)
   );

   demux_lane #(.WIDTH(WIDTH)) u_lane_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load[LANE_B]),
      .d     (Din),
      .q     (QB)
   );

   demux_lane #(.WIDTH(WIDTH)) u_lane_c (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load[LANE_C]),
      .d     (Din),
      .q     (QC)
   );

   demux_lane #(.WIDTH(WIDTH)) u_lane_d (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load[LANE_D]),
      .d     (Din),
      .q     (QD)
   );

   // Round-robin pointer: advances on each round-robin write, cleared by Clr
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Ptr <= LANE_A;
      end else if (Clr) begin
         Ptr <= LANE_A;
      end else if (En && mode_e'(Mode) == MODE_RR) begin
         Ptr <= Ptr + 2'd1;
      end
   end

   // Frame tracking: valid bits plus single-cycle Done / Ovr strobes.
   // A rewrite of a valid lane leaves Vld alone; since a full frame is
   // cleared on the edge it completes, a rewrite can never also complete
   // a frame, so Done and Ovr are mutually exclusive.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Vld  <= '0;
         Done <= 1'b0;
         Ovr  <= 1'b0;
      end else begin
         Done <= 1'b0;
         Ovr  <= 1'b0;
         if (Clr) begin
            Vld <= '0;
         end else if (ctl.wr) begin
            if (ctl.hit) begin
               Ovr <= 1'b1;
            end else if (ctl.full) begin
               Done <= 1'b1;
               Vld  <= '0;
            end else begin
               Vld <= Vld | ctl.oh;
            end
         end
      end
   end

endmodule

// File: tb/tb_demux_1t4r.sv
// Self-checking bench for demux_1t4r (WIDTH=8). A table of stimulus records
// with hand-derived expected state is driven one per cycle; each record is
// pushed to a scoreboard when driven and compared when the DUT has updated.
// A few hand-written sequences cover the Done pulse width and reset timing.
module tb_demux_1t4r;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din;
   logic         en;
   logic         mode;
   logic [1:0]   sel;
   logic         clr;
   logic [W-1:0] qa, qb, qc, qd;
   logic [3:0]   vld;
   logic [1:0]   ptr;
   logic         done;
   logic         ovr;

   int checks   = 0;
   int failures = 0;

   demux_1t4r #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Din   (din),
      .En    (en),
      .Mode  (mode),
      .Sel   (sel),
      .Clr   (clr),
      .QA    (qa),
      .QB    (qb),
      .QC    (qc),
      .QD    (qd),
      .Vld   (vld),
      .Ptr   (ptr),
      .Done  (done),
      .Ovr   (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         rst_n;
      logic         en;
      logic         mode;
      logic [1:0]   sel;
      logic         clr;
      logic [W-1:0] din;
      logic [W-1:0] qa, qb, qc, qd;
      logic [3:0]   vld;
      logic [1:0]   ptr;
      logic         done;
      logic         ovr;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(
      input string name, input logic r, input logic e, input logic m,
      input logic [1:0] s, input logic c, input logic [W-1:0] d,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] cc, input logic [W-1:0] dd,
      input logic [3:0] v, input logic [1:0] p, input logic dn, input logic ov);
      vec_t t;
      t.name = name; t.rst_n = r; t.en = e; t.mode = m; t.sel = s; t.clr = c;
      t.din = d; t.qa = a; t.qb = b; t.qc = cc; t.qd = dd;
      t.vld = v; t.ptr = p; t.done = dn; t.ovr = ov;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: one expected record per edge, sampled 1 time unit after it
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         vec_t e;
         e = sb.pop_front();
         check({e.name, ".QA"},   32'(qa),   32'(e.qa));
         check({e.name, ".QB"},   32'(qb),   32'(e.qb));
         check({e.name, ".QC"},   32'(qc),   32'(e.qc));
         check({e.name, ".QD"},   32'(qd),   32'(e.qd));
         check({e.name, ".Vld"},  32'(vld),  32'(e.vld));
         check({e.name, ".Ptr"},  32'(ptr),  32'(e.ptr));
         check({e.name, ".Done"}, 32'(done), 32'(e.done));
         check({e.name, ".Ovr"},  32'(ovr),  32'(e.ovr));
      end
   end

   task automatic drive(input logic r, input logic e, input logic m,
                        input logic [1:0] s, input logic c, input logic [W-1:0] d);
      @(negedge clk);
      rst_n = r; en = e; mode = m; sel = s; clr = c; din = d;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 2'd0; clr = 1'b0; din = '0;

      //        name        rst en md sel clr din     QA     QB     QC     QD     Vld      Ptr  Dn Ov
      vecs.push_back(mk("rst0",  0, 1, 0, 0, 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("rst1",  0, 1, 1, 3, 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("dirC",  1, 1, 0, 2, 0, 8'h5A, 8'h00, 8'h00, 8'h5A, 8'h00, 4'b0100, 0, 0, 0));
      vecs.push_back(mk("dirA",  1, 1, 0, 0, 0, 8'h11, 8'h11, 8'h00, 8'h5A, 8'h00, 4'b0101, 0, 0, 0));
      vecs.push_back(mk("idle1", 1, 0, 0, 1, 0, 8'hEE, 8'h11, 8'h00, 8'h5A, 8'h00, 4'b0101, 0, 0, 0));
      vecs.push_back(mk("clr1",  1, 0, 0, 0, 1, 8'h00, 8'h11, 8'h00, 8'h5A, 8'h00, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("rr0",   1, 1, 1, 3, 0, 8'hA0, 8'hA0, 8'h00, 8'h5A, 8'h00, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("rr1",   1, 1, 1, 3, 0, 8'hA1, 8'hA0, 8'hA1, 8'h5A, 8'h00, 4'b0011, 2, 0, 0));
      vecs.push_back(mk("rr2",   1, 1, 1, 0, 0, 8'hA2, 8'hA0, 8'hA1, 8'hA2, 8'h00, 4'b0111, 3, 0, 0));
      vecs.push_back(mk("rr3",   1, 1, 1, 0, 0, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b0000, 0, 1, 0));
      vecs.push_back(mk("rrpost",1, 0, 1, 0, 0, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("ovr0",  1, 1, 0, 1, 0, 8'h22, 8'hA0, 8'h22, 8'hA2, 8'hA3, 4'b0010, 0, 0, 0));
      vecs.push_back(mk("ovr1",  1, 1, 0, 1, 0, 8'h33, 8'hA0, 8'h33, 8'hA2, 8'hA3, 4'b0010, 0, 0, 1));
      vecs.push_back(mk("ovr2",  1, 0, 0, 1, 0, 8'h44, 8'hA0, 8'h33, 8'hA2, 8'hA3, 4'b0010, 0, 0, 0));
      vecs.push_back(mk("clr2",  1, 0, 1, 0, 1, 8'h00, 8'hA0, 8'h33, 8'hA2, 8'hA3, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("pre0",  1, 1, 1, 0, 0, 8'h44, 8'h44, 8'h33, 8'hA2, 8'hA3, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("pre1",  1, 1, 1, 0, 0, 8'h55, 8'h44, 8'h55, 8'hA2, 8'hA3, 4'b0011, 2, 0, 0));
      vecs.push_back(mk("clrwr", 1, 1, 1, 0, 1, 8'hFF, 8'h44, 8'h55, 8'hA2, 8'hA3, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("ms0",   1, 1, 1, 0, 0, 8'h61, 8'h61, 8'h55, 8'hA2, 8'hA3, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("ms1",   1, 1, 1, 0, 0, 8'h62, 8'h61, 8'h62, 8'hA2, 8'hA3, 4'b0011, 2, 0, 0));
      vecs.push_back(mk("msdir", 1, 1, 0, 3, 0, 8'h63, 8'h61, 8'h62, 8'hA2, 8'h63, 4'b1011, 2, 0, 0));
      vecs.push_back(mk("msrr",  1, 1, 1, 0, 0, 8'h64, 8'h61, 8'h62, 8'h64, 8'h63, 4'b0000, 3, 1, 0));
      vecs.push_back(mk("mspost",1, 0, 1, 0, 0, 8'h00, 8'h61, 8'h62, 8'h64, 8'h63, 4'b0000, 3, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].clr, vecs[i].din);
         sb.push_back(vecs[i]);
      end

      // Drain the scoreboard within a bounded number of edges
      for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
      #2;
      check("sb_drain", 32'(sb.size()), 32'd0);
      sb.delete();

      // Direct-mode frame in reverse lane order; Done must rise once and drop
      drive(1, 1, 0, 3, 0, 8'h70);
      drive(1, 1, 0, 2, 0, 8'h71);
      drive(1, 1, 0, 1, 0, 8'h72);
      drive(1, 1, 0, 0, 0, 8'h73);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
            if (i == 0) begin
               en = 1'b0;
            end
         end
         check("dir_frame.Done_seen", 32'(seen), 32'd1);
         check("dir_frame.Vld", 32'(vld), 32'd0);
         check("dir_frame.Ovr", 32'(ovr), 32'd0);
         check("dir_frame.Ptr_held", 32'(ptr), 32'd3);
         check("dir_frame.Q", {qa, qb, qc, qd}, 32'h73727170);
         @(posedge clk);
         #1;
         check("dir_frame.Done_drop", 32'(done), 32'd0);
      end

      // Reset is synchronous: outputs hold until the edge that samples rst_n=0
      drive(0, 1, 1, 0, 0, 8'hFF);
      #1;
      check("sync_rst.QD_before_edge", 32'(qd), 32'h70);
      @(posedge clk);
      #1;
      check("sync_rst.Q_after_edge", {qa, qb, qc, qd}, 32'h0);
      check("sync_rst.Ptr", 32'(ptr), 32'd0);
      drive(1, 0, 0, 0, 0, 8'h00);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
